// File: rtl/slc3_mem_responder.sv
// slc3_mem_responder: services SLC-3 single-word memory requests against async SRAM plus one I/O word.
module slc3_mem_responder #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset_ah,
  input  logic        Mem_req,
  input  logic        Mem_we,
  input  logic [15:0] Mem_addr,
  input  logic [15:0] Mem_wdata,
  output logic [15:0] Mem_rdata,
  output logic        Mem_ready,
  input  logic [15:0] Switches,
  output logic [15:0] Hex_out,
  output logic [19:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_out,
  output logic        SRAM_DQ_oe,
  input  logic [15:0] SRAM_DQ_in,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N
);
  typedef enum logic [2:0] {IDLE, RD_ACC, WR_SETUP, WR_PULSE, WR_HOLD, RESP} state_t;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);
  state_t state, nxt;
  logic [3:0] cnt;
  logic [15:0] addr, wdata;
  always_ff @(posedge Clk) begin
    if (Reset_ah) begin
      state <= IDLE;
      cnt <= '0;
      addr <= '0;
      wdata <= '0;
      Mem_rdata <= '0;
      Hex_out <= '0;
    end else begin
      state <= nxt;
      if (state == RD_ACC || state == WR_PULSE) cnt <= cnt - 4'd1;
      if (state == WR_SETUP) cnt <= CNT_INIT;
      if (state == RD_ACC && cnt == 4'd0) Mem_rdata <= SRAM_DQ_in;
      if (state == IDLE && Mem_req) begin
        addr <= Mem_addr;
        wdata <= Mem_wdata;
        cnt <= CNT_INIT;
        if (Mem_addr == IO_ADDR && Mem_we) Hex_out <= Mem_wdata;
        if (Mem_addr == IO_ADDR && !Mem_we) Mem_rdata <= Switches;
      end
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = !Mem_req ? IDLE : (Mem_addr == IO_ADDR) ? RESP : Mem_we ? WR_SETUP : RD_ACC;
      RD_ACC:   nxt = (cnt == 4'd0) ? RESP : RD_ACC;
      WR_SETUP: nxt = WR_PULSE;
      WR_PULSE: nxt = (cnt == 4'd0) ? WR_HOLD : WR_PULSE;
      WR_HOLD:  nxt = RESP;
      default:  nxt = IDLE;
    endcase
  end
  // strobes decode straight from state so OE_N and WE_N can never overlap
  assign SRAM_CE_N   = !(state inside {RD_ACC, WR_SETUP, WR_PULSE, WR_HOLD});
  assign SRAM_OE_N   = state != RD_ACC;
  assign SRAM_WE_N   = state != WR_PULSE;
  assign SRAM_DQ_oe  = state inside {WR_SETUP, WR_PULSE, WR_HOLD};
  assign Mem_ready   = state == RESP;
  assign SRAM_ADDR   = {4'b0, addr};
  assign SRAM_DQ_out = wdata;
endmodule

// File: doc/slc3_mem_responder.md
# slc3_mem_responder

Memory-side responder for the SLC-3 datapath. It accepts single-word read/write requests issued from the MAR/MDR side of the CPU and services them against an asynchronous SRAM with multi-cycle strobe timing. It also decodes one memory-mapped I/O word (switches in, hex display out). It answers each request with a one-cycle ready pulse; on reads, the returned word is the data the datapath loads into MDR when MIO_EN is set.

## Interface
- WAIT_CYCLES, 2, cycles OE_N/WE_N held active per SRAM access; legal range 1..15
- IO_ADDR, 16'hFFFF, CPU address decoded as the I/O word instead of SRAM
- Clk  input  1  system clock; all state changes on posedge
- Reset_ah  input  1  synchronous, active-high reset
- Mem_req  input  1  CPU request, level; sampled only in IDLE
- Mem_we  input  1  1 = write, 0 = read; qualified by Mem_req
- Mem_addr  input  16  word address (MAR)
- Mem_wdata  input  16  write data (MDR)
- Mem_rdata  output  16  read data to MDR_In; reset 16'h0000
- Mem_ready  output  1  one-cycle completion pulse; reset 0
- Switches  input  16  value returned on I/O reads
- Hex_out  output  16  I/O write register driving hex displays; reset 16'h0000
- SRAM_ADDR  output  20  {4'b0, latched address}; reset 0
- SRAM_DQ_out  output  16  write data driven to SRAM; reset 0
- SRAM_DQ_oe  output  1  1 = drive SRAM_DQ_out onto pins; reset 0
- SRAM_DQ_in  input  16  data from SRAM pins
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N  output  1 each  active-low strobes; reset 1

## Operation
- States: IDLE, RD_ACC, WR_SETUP, WR_PULSE, WR_HOLD, RESP.
- IDLE: all strobes high; SRAM_DQ_oe=0. If Mem_req=1, latch addr, wdata and we, then:
  - addr==IO_ADDR, read: Mem_rdata<=Switches and go to RESP.
  - addr==IO_ADDR, write: Hex_out<=Mem_wdata and go to RESP. SRAM strobes are never touched.
  - SRAM read: go to RD_ACC with cnt=WAIT_CYCLES-1.
  - SRAM write: go to WR_SETUP.
- RD_ACC: CE_N=0, OE_N=0, WE_N=1. Decrement cnt each cycle. At cnt==0, capture Mem_rdata<=SRAM_DQ_in and go to RESP.
- WR_SETUP (1 cycle): CE_N=0, WE_N=1, SRAM_DQ_oe=1. Load cnt=WAIT_CYCLES-1 and go to WR_PULSE.
- WR_PULSE: CE_N=0, WE_N=0, SRAM_DQ_oe=1. At cnt==0, go to WR_HOLD.
- WR_HOLD (1 cycle): CE_N=0, WE_N=1, SRAM_DQ_oe=1. Go to RESP.
- RESP (1 cycle): Mem_ready=1, strobes high, SRAM_DQ_oe=0. Go to IDLE.
- Mem_rdata holds its value until the next read completes; writes do not alter it.
- OE_N and WE_N are never low in the same cycle. SRAM_DQ_oe=1 only while WE_N-bracketing write states are active.
- Request inputs are ignored outside IDLE. Changes to Mem_addr/Mem_wdata mid-transaction have no effect.

## Timing
- Let cycle 0 be the edge at which IDLE samples Mem_req=1.
- Latency to the Mem_ready pulse:
  - I/O read or write: cycle 1 (2 edges).
  - SRAM read: cycle WAIT_CYCLES+1.
  - SRAM write: cycle WAIT_CYCLES+3.
- Mem_rdata is valid in the Mem_ready cycle and remains stable afterwards.
- Hex_out updates at cycle 1.
- Back-to-back transactions: if Mem_req is still high in the IDLE cycle after RESP, a new transaction starts. The CPU must drop Mem_req on Mem_ready to avoid a repeat.
- Reset at any state: on the next edge go to IDLE and apply all reset values above. An in-flight write may be truncated; no Mem_ready is issued for it.
- Reset has priority over Mem_req in the same cycle.
- WAIT_CYCLES=1: RD_ACC and WR_PULSE each last exactly one cycle.

## Test plan
- Reset, then SRAM read at 16'h0010 (model returns 16'hBEEF), WAIT_CYCLES=2 -> OE_N low for 2 cycles; Mem_ready at cycle 3; Mem_rdata=16'hBEEF; SRAM_ADDR=20'h00010.
- SRAM write 16'h1234 to 16'h0020 -> WE_N low exactly 2 cycles; CE_N low and SRAM_DQ_oe=1 for 4 cycles; Mem_ready at cycle 5; a following read of 16'h0020 returns 16'h1234.
- I/O read at 16'hFFFF with Switches=16'h00A5 -> Mem_ready at cycle 1; Mem_rdata=16'h00A5; CE_N stays 1 throughout.
- I/O write 16'h0C3F to 16'hFFFF -> Hex_out=16'h0C3F at cycle 1; then an SRAM write leaves Hex_out unchanged.
- Mem_req held high across two reads (16'h0001, then 16'h0002) -> two Mem_ready pulses separated by one IDLE cycle; Mem_addr change during RD_ACC is ignored.
- Reset_ah asserted during WR_PULSE -> next cycle WE_N=1, CE_N=1, SRAM_DQ_oe=0, Mem_ready never pulses, Mem_rdata=0, Hex_out=0; state accepts a new request.
